// File: rtl/bram_master_pkg.sv
// Shared types and default sizing for the BRAM burst master.
// The state enum is used by the top-level FSM; the defaults seed its parameters.
package bram_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_ADDRESS_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_DEPTH         = 64;
  localparam int DEFAULT_LEN_WIDTH     = 7;

endpackage

// File: rtl/bram_rd_out_reg.sv
// One-entry read output register: a load captures a word and marks it valid,
// a consume without a load empties it. Data holds its last value when empty.
module bram_rd_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  n_clr,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  input  logic                  i_consume,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  // A load wins over a consume so a same-cycle refill keeps the stream gapless.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_load_data;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/bram_burst_master.sv
// Burst master for a single-port BRAM: takes one command at a time and streams
// write words in or read words out at one word per cycle over valid/ready.
module bram_burst_master
  import bram_master_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int LEN_WIDTH     = DEFAULT_LEN_WIDTH
) (
  input  logic                     clk,
  input  logic                     n_clr,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_read_en,
  output logic                     mem_write_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  // DEPTH is a power of two, so masking the pointer gives the modulo wrap.
  localparam logic [ADDRESS_WIDTH-1:0] PTR_MASK = ADDRESS_WIDTH'(DEPTH - 1);

  state_t                   r_state;
  state_t                   w_next;
  logic [ADDRESS_WIDTH-1:0] r_ptr;
  logic [LEN_WIDTH-1:0]     r_cnt;

  logic                     w_accept;
  logic                     w_cnt_zero;
  logic                     w_wr_hs;
  logic                     w_issue;
  logic                     w_consume;
  logic                     w_rd_valid;
  logic [DATA_WIDTH-1:0]    w_rd_data;

  assign w_accept   = (r_state == IDLE) && cmd_valid;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_wr_hs    = (r_state == WRITE) && wr_valid;
  // A new read may go out only if the output slot is empty or being drained.
  assign w_issue    = (r_state == READ) && !w_cnt_zero && (!w_rd_valid || rd_ready);
  assign w_consume  = w_rd_valid && rd_ready;

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    cmd_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    wr_ready     = 1'b0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            w_next = DONE;
          end else if (cmd_write) begin
            w_next = WRITE;
          end else begin
            w_next = READ;
          end
        end
      end
      WRITE: begin
        busy         = 1'b1;
        wr_ready     = 1'b1;
        mem_write_en = wr_valid;
        if (w_wr_hs && (r_cnt == LEN_WIDTH'(1))) begin
          w_next = DONE;
        end
      end
      READ: begin
        busy        = 1'b1;
        mem_read_en = w_issue;
        // Finish only once every issued word has left the output register.
        if (w_cnt_zero && (!w_rd_valid || rd_ready)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_ptr <= cmd_addr & PTR_MASK;
      r_cnt <= cmd_len;
    end else if (w_wr_hs || w_issue) begin
      r_ptr <= (r_ptr + ADDRESS_WIDTH'(1)) & PTR_MASK;
      r_cnt <= r_cnt - LEN_WIDTH'(1);
    end
  end

  bram_rd_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_out (
    .clk         (clk),
    .n_clr       (n_clr),
    .i_load      (w_issue),
    .i_load_data (mem_rdata),
    .i_consume   (w_consume),
    .o_valid     (w_rd_valid),
    .o_data      (w_rd_data)
  );

  assign rd_valid  = w_rd_valid;
  assign rd_data   = w_rd_data;
  assign mem_addr  = r_ptr;
  assign mem_wdata = wr_data;

endmodule

// File: tb/tb_bram_burst_master.sv
// Bench for bram_burst_master: a 64-entry BRAM model, a transaction-level
// reference model checked every cycle, and directed bursts with literal expectations.
module tb_bram_burst_master;

  localparam int P_IDLE = 0;
  localparam int P_BUSY = 1;
  localparam int P_DONE = 2;

  logic        clk = 1'b0;
  logic        n_clr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [6:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errorCount = 0;
  int checkCount = 0;

  logic [31:0] bram   [64] = '{default: '0};
  logic [31:0] refMem [64] = '{default: '0};

  int          modelPhase = P_IDLE;
  int          modelStart = 0;
  int          modelLen   = 0;
  int          modelK     = 0;
  bit          modelIsWr  = 1'b0;
  logic [31:0] rdQ[$];
  logic [31:0] lastRd = '0;

  logic [31:0] rxQ[$];
  logic [31:0] wrAddrQ[$];
  logic [31:0] wrBuf   [8];
  logic [31:0] expList [8];

  bram_burst_master dut (
    .clk          (clk),
    .n_clr        (n_clr),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port BRAM: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_write_en) bram[mem_addr[5:0]] <= mem_wdata;
  end
  assign mem_rdata = bram[mem_addr[5:0]];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model, sampled mid-cycle: it predicts every output from the
  // burst rules and then advances by the handshakes of the coming edge.
  always @(negedge clk) begin : refModel
    logic        expWrEn;
    logic        expIssue;
    logic        expRdValid;
    logic [31:0] expAddr;
    if (!n_clr) begin
      modelPhase = P_IDLE;
      rdQ.delete();
      lastRd = '0;
    end else begin
      expAddr    = 32'((modelStart + modelK) % 64);
      expRdValid = (rdQ.size() != 0);
      expWrEn    = (modelPhase == P_BUSY) && modelIsWr && wr_valid;
      expIssue   = (modelPhase == P_BUSY) && !modelIsWr && (modelK < modelLen) &&
                   (!expRdValid || rd_ready);

      checkOutput("cmdReady", {31'd0, cmd_ready}, {31'd0, modelPhase == P_IDLE});
      checkOutput("busy", {31'd0, busy}, {31'd0, modelPhase == P_BUSY});
      checkOutput("done", {31'd0, done}, {31'd0, modelPhase == P_DONE});
      checkOutput("wrReady", {31'd0, wr_ready}, {31'd0, (modelPhase == P_BUSY) && modelIsWr});
      checkOutput("memWriteEn", {31'd0, mem_write_en}, {31'd0, expWrEn});
      checkOutput("memReadEn", {31'd0, mem_read_en}, {31'd0, expIssue});
      checkOutput("memWdata", mem_wdata, wr_data);
      checkOutput("rdValid", {31'd0, rd_valid}, {31'd0, expRdValid});
      checkOutput("rdData", rd_data, expRdValid ? rdQ[0] : lastRd);
      if (expWrEn || expIssue) checkOutput("memAddr", mem_addr, expAddr);

      if (mem_write_en) wrAddrQ.push_back(mem_addr);
      if (rd_valid && rd_ready) rxQ.push_back(rd_data);

      case (modelPhase)
        P_IDLE: begin
          if (cmd_valid) begin
            modelStart = int'(cmd_addr % 64);
            modelLen   = int'(cmd_len);
            modelK     = 0;
            modelIsWr  = cmd_write;
            modelPhase = (cmd_len == 0) ? P_DONE : P_BUSY;
          end
        end
        P_BUSY: begin
          if (modelIsWr) begin
            if (wr_valid) begin
              refMem[expAddr[5:0]] = wr_data;
              modelK++;
              if (modelK == modelLen) modelPhase = P_DONE;
            end
          end else begin
            if (expRdValid && rd_ready) void'(rdQ.pop_front());
            if (expIssue) begin
              rdQ.push_back(refMem[expAddr[5:0]]);
              lastRd = refMem[expAddr[5:0]];
              modelK++;
            end
            if (modelK == modelLen && rdQ.size() == 0) modelPhase = P_DONE;
          end
        end
        default: modelPhase = P_IDLE;
      endcase
    end
  end

  task automatic applyStimulus(input logic isWrite, input logic [31:0] addr, input logic [6:0] len);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = isWrite;
    cmd_addr  = addr;
    cmd_len   = len;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmdAccept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic writeWords(input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      wr_valid = 1'b1;
      wr_data  = wrBuf[i];
      @(negedge clk);
      while (!wr_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      checkOutput("wrReadyWait", {31'd0, wr_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic readBurst(input logic [3:0] pat);
    int c = 0;
    rd_ready = pat[0];
    @(negedge clk);
    while (!done && c < 200) begin
      @(posedge clk);
      #1;
      c++;
      rd_ready = pat[c % 4];
      @(negedge clk);
    end
    checkOutput("readDone", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
  endtask

  task automatic checkList(input string tag, input int n, input bit useAddr);
    int sz;
    sz = useAddr ? wrAddrQ.size() : rxQ.size();
    checkOutput({tag, "Count"}, 32'(sz), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < sz) checkOutput(tag, useAddr ? wrAddrQ[i] : rxQ[i], expList[i]);
      else        checkOutput(tag, 32'hFFFF_FFFF, expList[i]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_clr     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;
    #2;
    checkOutput("rstCmdReady", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkOutput("rstRdValid", {31'd0, rd_valid}, 32'd0);
    checkOutput("rstRdData", rd_data, 32'd0);
    checkOutput("rstMemAddr", mem_addr, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    n_clr = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] write burst addr=5 len=3");
    wrAddrQ.delete();
    wrBuf[0] = 32'hA; wrBuf[1] = 32'hB; wrBuf[2] = 32'hC;
    applyStimulus(1'b1, 32'd5, 7'd3);
    writeWords(3);
    @(negedge clk);
    checkOutput("writeDonePulse", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    expList[0] = 32'd5; expList[1] = 32'd6; expList[2] = 32'd7;
    checkList("writeAddr", 3, 1'b1);
    checkOutput("bram5", bram[5], 32'hA);
    checkOutput("bram7", bram[7], 32'hC);

    $display("[TB] read burst addr=5 len=3");
    rxQ.delete();
    applyStimulus(1'b0, 32'd5, 7'd3);
    readBurst(4'b1111);
    expList[0] = 32'hA; expList[1] = 32'hB; expList[2] = 32'hC;
    checkList("readData", 3, 1'b0);

    $display("[TB] wrap write/read at addr=62 len=4");
    wrAddrQ.delete();
    wrBuf[0] = 32'h11; wrBuf[1] = 32'h22; wrBuf[2] = 32'h33; wrBuf[3] = 32'h44;
    applyStimulus(1'b1, 32'd62, 7'd4);
    writeWords(4);
    @(posedge clk);
    #1;
    expList[0] = 32'd62; expList[1] = 32'd63; expList[2] = 32'd0; expList[3] = 32'd1;
    checkList("wrapAddr", 4, 1'b1);
    rxQ.delete();
    applyStimulus(1'b0, 32'd62, 7'd4);
    readBurst(4'b1111);
    expList[0] = 32'h11; expList[1] = 32'h22; expList[2] = 32'h33; expList[3] = 32'h44;
    checkList("wrapData", 4, 1'b0);

    $display("[TB] read backpressure addr=10 len=4");
    wrBuf[0] = 32'h5A0; wrBuf[1] = 32'h5A1; wrBuf[2] = 32'h5A2; wrBuf[3] = 32'h5A3;
    applyStimulus(1'b1, 32'd10, 7'd4);
    writeWords(4);
    @(posedge clk);
    #1;
    rxQ.delete();
    applyStimulus(1'b0, 32'd10, 7'd4);
    readBurst(4'b1001);
    expList[0] = 32'h5A0; expList[1] = 32'h5A1; expList[2] = 32'h5A2; expList[3] = 32'h5A3;
    checkList("bpData", 4, 1'b0);

    $display("[TB] zero-length command");
    applyStimulus(1'b1, 32'd7, 7'd0);
    @(negedge clk);
    checkOutput("len0Done", {31'd0, done}, 32'd1);
    checkOutput("len0NoWrite", {31'd0, mem_write_en}, 32'd0);
    checkOutput("len0NoRead", {31'd0, mem_read_en}, 32'd0);
    checkOutput("len0CmdReadyLow", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("len0CmdReadyBack", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] reset during write burst addr=20 len=5");
    applyStimulus(1'b1, 32'd20, 7'd5);
    wr_valid = 1'b1;
    wr_data  = 32'h100;
    @(posedge clk);
    #1;
    wr_data  = 32'h101;
    @(posedge clk);
    #1;
    wr_data  = 32'h102;
    n_clr    = 1'b0;
    #1;
    checkOutput("midRstWriteEn", {31'd0, mem_write_en}, 32'd0);
    checkOutput("midRstWrReady", {31'd0, wr_ready}, 32'd0);
    checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
    checkOutput("midRstCmdReady", {31'd0, cmd_ready}, 32'd1);
    checkOutput("midRstMemAddr", mem_addr, 32'd0);
    wr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_clr = 1'b1;
    @(posedge clk);
    #1;
    rxQ.delete();
    applyStimulus(1'b0, 32'd20, 7'd5);
    readBurst(4'b1111);
    expList[0] = 32'h100; expList[1] = 32'h101;
    expList[2] = 32'h0;   expList[3] = 32'h0; expList[4] = 32'h0;
    checkList("postRstData", 5, 1'b0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bram_burst_master.md
# bram_burst_master

Burst initiator that drives the single-port BRAM's command side: read_en, write_en, addr, data_in, with combinational data_out returning. Accepts one command at a time (direction, start address, length) over a valid/ready handshake. Writes stream in, and reads stream out, over valid/ready at one word per cycle. Sits between datapath clients and the 64-entry single-port BRAM, so clients never touch raw memory strobes.

## Interface
- ADDRESS_WIDTH, 32, width of mem_addr and cmd_addr
- DATA_WIDTH, 32, word width
- DEPTH, 64, BRAM entries; power of two; addresses wrap modulo DEPTH
- LEN_WIDTH, 7, burst length width in words (0..127)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- n_clr  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDRESS_WIDTH  start address, taken modulo DEPTH
- cmd_len  in  LEN_WIDTH  word count
- wr_valid  in  1  write word offered
- wr_ready  out  1  write word accepted
- wr_data  in  DATA_WIDTH  write word
- rd_valid  out  1  read word available
- rd_ready  in  1  consumer takes read word
- rd_data  out  DATA_WIDTH  read word (registered)
- busy  out  1  high in WRITE/READ
- done  out  1  one-cycle pulse at burst completion
- mem_read_en  out  1  to BRAM read_en
- mem_write_en  out  1  to BRAM write_en
- mem_addr  out  ADDRESS_WIDTH  to BRAM addr; pointer zero-extended
- mem_wdata  out  DATA_WIDTH  to BRAM data_in; equals wr_data
- mem_rdata  in  DATA_WIDTH  from BRAM data_out (combinational)

## Operation
FSM states: IDLE, WRITE, READ, DONE.
- IDLE: cmd_ready=1.
  - On cmd_valid, latch ptr=cmd_addr mod DEPTH and cnt=cmd_len.
  - cmd_len=0 goes to DONE. Otherwise go to WRITE if cmd_write, else READ.
- WRITE: wr_ready=1; mem_write_en=wr_valid (combinational).
  - Each wr_valid handshake writes wr_data at ptr on that edge, then ptr++ (wraps DEPTH-1 to 0) and cnt--.
  - The handshake that takes cnt to 0 moves to DONE.
- READ: issue when cnt!=0 and (rd_valid=0 or rd_ready=1).
  - Issue drives mem_read_en=1 and captures mem_rdata into rd_data on the edge.
  - On issue, set rd_valid, ptr++ and cnt--.
  - If rd_valid and rd_ready with no issue, clear rd_valid.
  - Move to DONE when cnt=0 and the final word is consumed (rd_valid&rd_ready, or rd_valid already 0).
- DONE: done=1 for exactly one cycle, then IDLE.
- Idle outputs: mem_read_en and mem_write_en low outside their issuing conditions; wr_ready=0 outside WRITE.
- cmd_len greater than DEPTH wraps and overwrites or rereads earlier entries; this is legal.
- rd_data holds its last value when rd_valid=0.

## Timing
- Reset (asynchronous): state=IDLE, ptr=0, cnt=0, rd_valid=0, rd_data=0, done=0, busy=0, cmd_ready=1. mem_read_en and mem_write_en are 0 immediately.
- Reset mid-burst abandons the burst; writes already performed stay in the BRAM.
- Command accept to first memory strobe: 1 cycle.
- Write throughput: 1 word/cycle. wr_data is written on the same edge as its handshake.
- Read latency: issue edge to rd_valid high is 1 cycle. Throughput is 1 word/cycle with rd_ready held high.
- Read backpressure: rd_ready low with rd_valid high stalls issue. rd_data stays stable and the pointer holds.
- Completion: done rises the cycle after the last write handshake, or after the last read consumption. For len=0, done rises the cycle after accept.
- Next accept: the cycle after done. Minimum command-to-command spacing is len+2 cycles.

## Structure
- Package bram_master_pkg holds the state enum (IDLE, WRITE, READ, DONE) and the default DEPTH/LEN_WIDTH constants.
- One sub-module, bram_rd_out_reg: a one-entry output register (rd_valid/rd_data with load and consume) instantiated in the read path.
- Pointer wrap uses ptr mask DEPTH-1; no divide.

## Test plan
- Write burst, addr=5, len=3, data 0xA,0xB,0xC, wr_valid held: mem_write_en high 3 consecutive cycles at addrs 5,6,7; done pulses 1 cycle later.
- Read burst, addr=5, len=3, rd_ready held: rd_data 0xA,0xB,0xC on 3 consecutive cycles starting 1 cycle after first mem_read_en; then done.
- Wrap: write addr=62, len=4 -> writes land at 62,63,0,1; a read back at 62, len 4 returns the same order.
- Backpressure: read len=4 with rd_ready toggled 1,0,0,1…: no word lost or duplicated, rd_data stable while stalled, mem_read_en low during stall.
- len=0 command: no mem strobes; done high the cycle after accept; cmd_ready back 1 cycle later.
- n_clr asserted mid-write after 2 of 5 words: outputs go to reset values at once; only the first 2 words are present in the BRAM; a new command is accepted after release.
